// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constants
// and a constant-foldable clog2 used to size counters and the select port.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  // Mode number is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: divides iClk into SCLK half-periods while enabled and flags
// the leading, trailing and final edge one cycle ahead of the registered toggle.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 10
) (
  input  logic iClk,
  input  logic iRstn,
  input  logic enable,
  input  logic cpol,
  output logic sclk,
  output logic lead_stb,
  output logic trail_stb,
  output logic last_stb
);

  localparam int DIV_W  = clog2(CLK_DIV) + 1;
  localparam int EDGES  = 2 * DATA_WIDTH;
  localparam int EDGE_W = clog2(EDGES) + 1;

  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edge;
  logic              r_sclk;
  logic              w_wrap;

  // r_edge holds edges already issued, so the upcoming edge is odd (leading) when it is even
  assign w_wrap    = enable && (r_div == DIV_W'(CLK_DIV - 1));
  assign lead_stb  = w_wrap && !r_edge[0];
  assign trail_stb = w_wrap && r_edge[0];
  assign last_stb  = w_wrap && (r_edge == EDGE_W'(EDGES - 1));
  assign sclk      = r_sclk;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= 1'b0;
    end else if (!enable) begin
      r_div  <= '0;
      r_edge <= '0;
      r_sclk <= cpol;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_edge <= r_edge + 1'b1;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Handshaked SPI master: one frame per iStart, per-transfer CPOL/CPHA, one of
// NUM_SS active-low selects, all SPI pins driven straight from registers.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int DATA_WIDTH = 10,
  parameter  int NUM_SS     = 4,
  parameter  int CLK_DIV    = 4,
  parameter  int CS_SETUP   = 4,
  parameter  int CS_HOLD    = 4,
  localparam int SEL_W      = (clog2(NUM_SS) > 1) ? clog2(NUM_SS) : 1
) (
  input  logic                  iClk,
  input  logic                  iRstn,
  input  logic                  iStart,
  input  logic [SEL_W-1:0]      iSel,
  input  logic                  iCPOL,
  input  logic                  iCPHA,
  input  logic [DATA_WIDTH-1:0] iTx_Data,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [DATA_WIDTH-1:0] oRx_Data,
  output logic                  oSCLK,
  output logic [NUM_SS-1:0]     oSSn,
  output logic                  oMOSI,
  input  logic                  iMISO
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = clog2(CNT_MAX) + 1;

  spi_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [NUM_SS-1:0]     r_ssn;
  logic                  r_cpol;
  logic                  r_cpha;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0] w_mode;
  logic       w_cpha1;
  logic       w_cpol_nxt;
  logic       w_xfer;
  logic       w_lead;
  logic       w_trail;
  logic       w_last;
  logic       w_sample;
  logic       w_shift;
  logic       w_sclk;

  // An out-of-range index leaves every select high, so the frame still completes
  function automatic logic [NUM_SS-1:0] ssn_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (int'(sel) == i) v[i] = 1'b0;
    return v;
  endfunction

  assign w_mode   = {r_cpol, r_cpha};
  assign w_cpha1  = (w_mode == SPI_MODE1) || (w_mode == SPI_MODE3);
  assign w_xfer   = (r_state == ST_XFER);
  assign w_sample = w_cpha1 ? w_trail : w_lead;
  assign w_shift  = w_cpha1 ? w_lead : (w_trail && !w_last);

  // The new CPOL reaches SCLK on the accepting edge, so SETUP entry already idles correctly
  assign w_cpol_nxt = ((r_state == ST_IDLE) && iStart) ? iCPOL : r_cpol;

  spi_sclk_gen #(
    .CLK_DIV   (CLK_DIV),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sclk_gen (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .enable   (w_xfer),
    .cpol     (w_cpol_nxt),
    .sclk     (w_sclk),
    .lead_stb (w_lead),
    .trail_stb(w_trail),
    .last_stb (w_last)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_ssn     <= '1;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            // CPHA=0 puts the MSB out now, so the shifter is preloaded one bit ahead
            r_tx    <= iCPHA ? iTx_Data : {iTx_Data[DATA_WIDTH-2:0], 1'b0};
            r_mosi  <= iCPHA ? 1'b0 : iTx_Data[DATA_WIDTH-1];
            r_rx    <= '0;
            r_ssn   <= ssn_decode(iSel);
            r_cpol  <= iCPOL;
            r_cpha  <= iCPHA;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (w_sample) r_rx <= {r_rx[DATA_WIDTH-2:0], iMISO};
          if (w_shift) begin
            r_mosi <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
          if (w_last) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
            r_cnt   <= '0;
            r_ssn   <= '1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done    <= 1'b1;
          r_rx_data <= r_rx;
          r_mosi    <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oRx_Data = r_rx_data;
  assign oSCLK    = w_sclk;
  assign oSSn     = r_ssn;
  assign oMOSI    = r_mosi;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: a default instance driven against a mode-aware
// slave model, plus a fast 8-bit, 5-select instance wired MOSI->MISO.
module tb_spi_master_multi;

  localparam int LAT_A = 4 + 2 * 10 * 4 + 4 + 1;
  localparam int LAT_B = 4 + 2 * 8 * 1 + 4 + 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [9:0] tx = '0;
  logic       busy, done, sclk, mosi;
  logic [9:0] rx;
  logic [3:0] ssn;
  logic       miso = 1'b0;

  logic       b_start = 1'b0;
  logic [2:0] b_sel = '0;
  logic       b_cpol = 1'b0;
  logic       b_cpha = 1'b0;
  logic [7:0] b_tx = '0;
  logic       b_busy, b_done, b_sclk, b_mosi;
  logic [7:0] b_rx;
  logic [4:0] b_ssn;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Slave model state, owned by the monitor below
  logic [9:0] s_word = '0;
  logic [9:0] s_rx = '0;
  int         s_edges = 0;
  int         done_cnt = 0;
  int         falls = 0;
  logic       p_sclk = 1'b0;
  logic [3:0] p_ssn = 4'hF;

  // Frame settings the slave model follows, owned by the stimulus process
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [9:0] slave_next = '0;
  logic       a_last_cpol = 1'b0;
  logic [9:0] wv;

  spi_master_multi dut_a (
    .iClk(clk), .iRstn(rstn), .iStart(start), .iSel(sel), .iCPOL(cpol), .iCPHA(cpha),
    .iTx_Data(tx), .oBusy(busy), .oDone(done), .oRx_Data(rx), .oSCLK(sclk),
    .oSSn(ssn), .oMOSI(mosi), .iMISO(miso)
  );

  spi_master_multi #(.DATA_WIDTH(8), .NUM_SS(5), .CLK_DIV(1), .CS_SETUP(4), .CS_HOLD(4)) dut_b (
    .iClk(clk), .iRstn(rstn), .iStart(b_start), .iSel(b_sel), .iCPOL(b_cpol), .iCPHA(b_cpha),
    .iTx_Data(b_tx), .oBusy(b_busy), .oDone(b_done), .oRx_Data(b_rx), .oSCLK(b_sclk),
    .oSSn(b_ssn), .oMOSI(b_mosi), .iMISO(b_mosi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: leading edge is the move away from CPOL; CPHA selects which edge samples
  always @(negedge clk) begin
    logic lead;
    if (!rstn) miso = 1'b0;
    if (p_ssn == 4'hF && ssn != 4'hF) begin
      s_word  = slave_next;
      s_rx    = '0;
      s_edges = 0;
      falls   = falls + 1;
      if (!m_cpha) miso = s_word[9];
    end else if (ssn != 4'hF && p_ssn != 4'hF && sclk != p_sclk) begin
      s_edges = s_edges + 1;
      lead = (sclk != m_cpol);
      if (lead != m_cpha) begin
        s_rx = {s_rx[8:0], mosi};
      end else if (m_cpha) begin
        miso   = s_word[9];
        s_word = {s_word[8:0], 1'b0};
      end else begin
        s_word = {s_word[8:0], 1'b0};
        miso   = s_word[9];
      end
    end
    if (done) done_cnt = done_cnt + 1;
    p_sclk = sclk;
    p_ssn  = ssn;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [1:0] s, input logic pol, input logic pha,
                           input logic [9:0] t, input logic [9:0] sw, input logic [9:0] er);
    int   c0, d0;
    logic busy_bad, got;
    logic [3:0] ssn_first;
    check("idle_sclk", 32'(sclk), 32'(a_last_cpol));
    m_cpol = pol; m_cpha = pha; slave_next = sw;
    sel = s; cpol = pol; cpha = pha; tx = t; start = 1'b1;
    d0 = done_cnt;
    tick();
    c0 = cyc;
    ssn_first = ssn;
    check("setup_ssn", 32'(ssn_first), 32'(4'(~(4'b0001 << s))));
    check("setup_sclk", 32'(sclk), 32'(pol));
    check("setup_busy", 32'(busy), 32'd1);
    if (!pha) check("setup_mosi", 32'(mosi), 32'(t[9]));
    busy_bad = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (!busy) busy_bad = 1'b1;
      sel = 2'($urandom_range(0, 3)); cpol = 1'($urandom); cpha = 1'($urandom);
      tx = 10'($urandom); start = 1'($urandom);
      tick();
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc - c0), 32'(LAT_A));
    check("rx_data", 32'(rx), 32'(er));
    check("slave_rx", 32'(s_rx), 32'(t));
    check("sclk_edges", 32'(s_edges), 32'd20);
    check("end_sclk", 32'(sclk), 32'(pol));
    check("end_ssn", 32'(ssn), 32'hF);
    check("end_busy", 32'(busy), 32'd0);
    check("busy_held", 32'(busy_bad), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    a_last_cpol = pol;
  endtask

  task automatic hold_start_test();
    int   dq[$];
    int   f0;
    logic bad;
    logic [9:0] sw;
    sw = 10'($urandom);
    m_cpol = 1'b0; m_cpha = 1'b0; slave_next = sw;
    sel = 2'd1; cpol = 1'b0; cpha = 1'b0; tx = 10'($urandom); start = 1'b1;
    f0 = falls;
    bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done) begin
        dq.push_back(cyc);
        if (dq.size() == 3) begin start = 1'b0; break; end
      end else if (!busy) begin
        bad = 1'b1;
      end
    end
    check("hold_frames", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      check("hold_space1", 32'(dq[1] - dq[0]), 32'(LAT_A + 1));
      check("hold_space2", 32'(dq[2] - dq[1]), 32'(LAT_A + 1));
    end
    check("hold_falls", 32'(falls - f0), 32'd3);
    check("hold_busy", 32'(bad), 32'd0);
    check("hold_rx", 32'(rx), 32'(sw));
    repeat (3) tick();
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_ssn", 32'(ssn), 32'hF);
    a_last_cpol = 1'b0;
  endtask

  task automatic reset_test();
    int d0;
    m_cpol = 1'b0; m_cpha = 1'b1; slave_next = 10'($urandom);
    sel = 2'd0; cpol = 1'b0; cpha = 1'b1; tx = 10'($urandom); start = 1'b1;
    d0 = done_cnt;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (s_edges >= 7) break;
      tick();
    end
    check("rst_reach_e7", 32'(s_edges >= 7), 32'd1);
    check("rst_pre_sclk", 32'(sclk), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_ssn", 32'(ssn), 32'hF);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    a_last_cpol = 1'b0;
  endtask

  task automatic run_b(input logic [2:0] s, input logic pol, input logic pha, input logic [7:0] t);
    int   c0, tog, first, last;
    logic got, prev;
    logic [4:0] ssn_and;
    b_sel = s; b_cpol = pol; b_cpha = pha; b_tx = t; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    c0 = cyc;
    ssn_and = b_ssn;
    prev = b_sclk;
    tog = 0; first = 0; last = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (b_done) begin got = 1'b1; break; end
      ssn_and = ssn_and & b_ssn;
      if (b_sclk != prev) begin
        if (tog == 0) first = cyc;
        last = cyc;
        tog = tog + 1;
      end
      prev = b_sclk;
      tick();
    end
    check("b_done_seen", 32'(got), 32'd1);
    check("b_latency", 32'(cyc - c0), 32'(LAT_B));
    check("b_toggles", 32'(tog), 32'd16);
    check("b_edge_span", 32'(last - first), 32'd15);
    check("b_loopback", 32'(b_rx), 32'(t));
    check("b_ssn", 32'(ssn_and), (s < 3'd5) ? 32'(5'(~(5'b00001 << s))) : 32'h1F);
    check("b_end_sclk", 32'(b_sclk), 32'(pol));
    tick();
    check("b_done_pulse", 32'(b_done), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_ssn", 32'(ssn), 32'hF);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rx", 32'(rx), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();

    run_frame(2'd2, 1'b0, 1'b0, 10'h2A5, 10'h15A, 10'h15A);

    for (int m = 0; m < 4; m++) begin
      wv = 10'($urandom);
      run_frame(2'($urandom_range(0, 3)), m[1], m[0], 10'h3C3, wv, wv);
      run_frame(2'($urandom_range(0, 3)), m[1], m[0], 10'($urandom), s_rx, 10'h3C3);
    end

    repeat (4) begin
      wv = 10'($urandom);
      run_frame(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 10'($urandom), wv, wv);
    end

    hold_start_test();
    reset_test();
    wv = 10'($urandom);
    run_frame(2'd3, 1'b0, 1'b0, 10'($urandom), wv, wv);

    run_b(3'd0, 1'b0, 1'b0, 8'h81);
    run_b(3'd5, 1'b0, 1'b0, 8'h81);
    run_b(3'd4, 1'b1, 1'b1, 8'($urandom));
    run_b(3'd7, 1'b1, 1'b0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
